// File: rtl/page_walker_if.sv
// Translation request/response, base-register and physical-memory read signals of the page walker.
// slave: the walker; master: the MMU / bus side that drives requests and read data.
interface page_walker_if;
  logic [31:0] mmu_base_i;
  logic        mmu_we;
  logic [31:0] mmu_base_o;
  logic [31:0] v_addr_i;
  logic        v_lookup;
  logic [31:0] v_ent_o;
  logic        v_ack_o;
  logic [31:0] addr_o;
  logic        rd_o;
  logic [31:0] data_i;
  logic        ack_i;
  logic        page_fault;
  logic [31:0] page_fault_addr;

  modport slave (
    input  mmu_base_i, mmu_we, v_addr_i, v_lookup, data_i, ack_i,
    output mmu_base_o, v_ent_o, v_ack_o, addr_o, rd_o, page_fault, page_fault_addr
  );

  modport master (
    output mmu_base_i, mmu_we, v_addr_i, v_lookup, data_i, ack_i,
    input  mmu_base_o, v_ent_o, v_ack_o, addr_o, rd_o, page_fault, page_fault_addr
  );
endinterface

// File: rtl/page_walker.sv
// Two-level page-table walker with a round-robin fully-associative translation cache.
// Hit acks one cycle after lookup, miss one cycle after the second bus ack; reads are held until ack_i.
module page_walker #(
  parameter int ENTRIES = 4
) (
  input  logic          clk,
  input  logic          rst,
  page_walker_if.slave  bus
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    PDE,
    PTE,
    RESP,
    FAULT
  } state_e;

  state_e             state_q;
  logic [31:0]        base_q;
  logic [31:0]        v_ent_q;
  logic [31:0]        addr_q;
  logic [31:0]        pf_addr_q;
  logic               rd_q;
  logic               ack_q;
  logic               pf_q;
  logic [19:0]        page_q;
  logic [11:0]        off_q;

  logic [19:0]        tag_q [ENTRIES];
  logic [31:0]        ent_q [ENTRIES];
  logic [ENTRIES-1:0] vld_q;
  logic [PW-1:0]      ptr_q;

  logic               hit_d;
  logic [31:0]        hit_ent_d;

  // Fills happen only on a miss, so at most one valid tag can match.
  always_comb begin
    hit_d     = 1'b0;
    hit_ent_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld_q[i] && (tag_q[i] == bus.v_addr_i[31:12])) begin
        hit_d     = 1'b1;
        hit_ent_d = ent_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      v_ent_q   <= '0;
      addr_q    <= '0;
      pf_addr_q <= '0;
      rd_q      <= 1'b0;
      ack_q     <= 1'b0;
      pf_q      <= 1'b0;
      page_q    <= '0;
      off_q     <= '0;
      vld_q     <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ent_q[i] <= '0;
      end
    end else if (bus.mmu_we) begin
      // New page directory: drop every cached translation and abandon any walk in flight.
      base_q  <= bus.mmu_base_i & 32'hFFFF_F000;
      vld_q   <= '0;
      ptr_q   <= '0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      pf_q    <= 1'b0;
      state_q <= IDLE;
    end else begin
      ack_q <= 1'b0;
      pf_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.v_lookup) begin
            page_q <= bus.v_addr_i[31:12];
            off_q  <= bus.v_addr_i[11:0];
            if (hit_d) begin
              v_ent_q <= hit_ent_d;
              ack_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              addr_q  <= {base_q[31:12], bus.v_addr_i[31:22], 2'b00};
              rd_q    <= 1'b1;
              state_q <= PDE;
            end
          end
        end
        PDE: begin
          if (bus.ack_i) begin
            if (!bus.data_i[0]) begin
              rd_q      <= 1'b0;
              pf_q      <= 1'b1;
              pf_addr_q <= {page_q, off_q};
              state_q   <= FAULT;
            end else begin
              addr_q  <= {bus.data_i[31:12], page_q[9:0], 2'b00};
              state_q <= PTE;
            end
          end
        end
        PTE: begin
          if (bus.ack_i) begin
            rd_q <= 1'b0;
            if (!bus.data_i[0]) begin
              pf_q      <= 1'b1;
              pf_addr_q <= {page_q, off_q};
              state_q   <= FAULT;
            end else begin
              tag_q[ptr_q] <= page_q;
              ent_q[ptr_q] <= bus.data_i;
              vld_q[ptr_q] <= 1'b1;
              ptr_q        <= ptr_q + PTR_ONE;
              v_ent_q      <= bus.data_i;
              // The MMU may have withdrawn or moved on; the fill still stands but the ack is dropped.
              ack_q        <= bus.v_lookup && (bus.v_addr_i[31:12] == page_q);
              state_q      <= RESP;
            end
          end
        end
        RESP:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mmu_base_o      = base_q;
  assign bus.v_ent_o         = v_ent_q;
  assign bus.v_ack_o         = ack_q;
  assign bus.addr_o          = addr_q;
  assign bus.rd_o            = rd_q;
  assign bus.page_fault      = pf_q;
  assign bus.page_fault_addr = pf_addr_q;

endmodule

// File: tb/tb_page_walker.sv
// Scoreboard bench for page_walker: directed lookups against a memory model, decoupled response monitor.
module tb_page_walker;

  logic clk = 1'b0;
  logic rst;

  page_walker_if pw_if ();

  page_walker #(.ENTRIES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pw_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fault;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem [logic [31:0]];

  int n_chk  = 0;
  int n_fail = 0;

  int          delay     = 0;
  bit          hold_en   = 1'b0;
  logic [31:0] hold_addr = 32'h0;
  bit          in_read   = 1'b0;
  int          wcnt      = 0;
  int          late_cnt  = 0;
  logic [31:0] cur_addr  = 32'h0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] pte_val(input int tbl);
    return 32'h0100_0003 | (tbl << 12);
  endfunction

  // Bus responder: acks each read after 'delay' waiting cycles, checks address order and stability.
  initial begin
    pw_if.ack_i  = 1'b0;
    pw_if.data_i = 32'h0;
    forever begin
      @(negedge clk);
      if (pw_if.ack_i) pw_if.ack_i = 1'b0;
      if (rst) begin
        in_read = 1'b0;
      end else if (late_cnt > 0) begin
        late_cnt--;
        if (late_cnt == 0) begin
          pw_if.data_i = 32'h0002_0001;
          pw_if.ack_i  = 1'b1;
        end
      end else if (pw_if.rd_o) begin
        if (!in_read) begin
          in_read  = 1'b1;
          cur_addr = pw_if.addr_o;
          wcnt     = 0;
        end else begin
          check("addr_stable", pw_if.addr_o, cur_addr);
        end
        if (hold_en && pw_if.addr_o == hold_addr) begin
          wcnt++;
        end else if (wcnt >= delay) begin
          if (exp_rd.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_read: addr_o %h, no read expected", pw_if.addr_o);
          end else begin
            check("read_addr", pw_if.addr_o, exp_rd.pop_front());
          end
          pw_if.data_i = mem_rd(pw_if.addr_o);
          pw_if.ack_i  = 1'b1;
          in_read      = 1'b0;
        end else begin
          wcnt++;
        end
      end else if (in_read) begin
        in_read = 1'b0;
        if (hold_en) begin
          late_cnt = 2;
        end else begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_held: rd_o dropped at %h before ack, expected held", cur_addr);
        end
      end
    end
  end

  // Response monitor: every ack or fault pulse must match the next expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (pw_if.v_ack_o || pw_if.page_fault)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp: ack=%b fault=%b ent=%h, no response expected",
                   pw_if.v_ack_o, pw_if.page_fault, pw_if.v_ent_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_is_fault", 32'(pw_if.page_fault), 32'(mon_e.is_fault));
          check("resp_is_ack", 32'(pw_if.v_ack_o), 32'(!mon_e.is_fault));
          if (mon_e.is_fault) check("fault_addr", pw_if.page_fault_addr, mon_e.val);
          else                check("v_ent", pw_if.v_ent_o, mon_e.val);
        end
      end
    end
  end

  task automatic push_ack(input logic [31:0] v);
    exp_t e;
    e.is_fault = 1'b0;
    e.val      = v;
    exp_q.push_back(e);
  endtask

  task automatic push_fault(input logic [31:0] v);
    exp_t e;
    e.is_fault = 1'b1;
    e.val      = v;
    exp_q.push_back(e);
  endtask

  task automatic do_lookup(input string name, input logic [31:0] va, input int exp_cyc);
    int cyc  = 0;
    bit done = 1'b0;
    pw_if.v_addr_i = va;
    pw_if.v_lookup = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pw_if.v_ack_o || pw_if.page_fault) done = 1'b1;
    end
    pw_if.v_lookup = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no response in %0d cycles, expected one", name, cyc);
    end else begin
      check({name, "_latency"}, cyc, exp_cyc);
    end
    @(negedge clk);
  endtask

  task automatic write_base(input logic [31:0] b, input logic [31:0] exp_b);
    pw_if.mmu_base_i = b;
    pw_if.mmu_we     = 1'b1;
    @(negedge clk);
    pw_if.mmu_we = 1'b0;
    check("mmu_base", pw_if.mmu_base_o, exp_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tbl;
    int cyc;
    rst              = 1'b1;
    pw_if.mmu_base_i = 32'h0;
    pw_if.mmu_we     = 1'b0;
    pw_if.v_addr_i   = 32'h0;
    pw_if.v_lookup   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_base", pw_if.mmu_base_o, 32'h0);
    check("rst_ent", pw_if.v_ent_o, 32'h0);
    check("rst_addr", pw_if.addr_o, 32'h0);
    check("rst_rd", 32'(pw_if.rd_o), 32'h0);
    check("rst_ack", 32'(pw_if.v_ack_o), 32'h0);
    check("rst_fault", 32'(pw_if.page_fault), 32'h0);
    check("rst_fault_addr", pw_if.page_fault_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    mem[32'h0001_0004] = 32'h0002_0001;
    mem[32'h0002_000C] = 32'h0055_5007;
    mem[32'h0001_0008] = 32'h0002_0000;
    for (int t = 'h10; t <= 'h16; t++) mem[32'h0002_0000 + t * 4] = pte_val(t);

    write_base(32'h0001_0ABC, 32'h0001_0000);

    // Full two-level walk
    exp_rd.push_back(32'h0001_0004);
    exp_rd.push_back(32'h0002_000C);
    push_ack(32'h0055_5007);
    do_lookup("walk1", 32'h0040_3ABC, 3);

    // Same page, different offset: cache hit, no bus traffic
    push_ack(32'h0055_5007);
    do_lookup("hit1", 32'h0040_3F00, 1);
    check("ent_hold", pw_if.v_ent_o, 32'h0055_5007);

    // Invalid PDE faults after one read, and is not cached
    exp_rd.push_back(32'h0001_0008);
    push_fault(32'h0080_0123);
    do_lookup("fault1", 32'h0080_0123, 2);
    exp_rd.push_back(32'h0001_0008);
    push_fault(32'h0080_0123);
    do_lookup("fault_retry", 32'h0080_0123, 2);

    // Round-robin replacement: ENTRIES+1 fills evict the first page
    write_base(32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 5; i++) begin
      tbl = 'h10 + i;
      exp_rd.push_back(32'h0001_0004);
      exp_rd.push_back(32'h0002_0000 + tbl * 4);
      push_ack(pte_val(tbl));
      do_lookup("fill", 32'h0040_0000 | (tbl << 12), 3);
    end
    check("fault_addr_hold", pw_if.page_fault_addr, 32'h0080_0123);
    push_ack(32'h0101_4003);
    do_lookup("hit_last", 32'h0041_4000, 1);
    push_ack(32'h0101_1003);
    do_lookup("hit_second", 32'h0041_1000, 1);
    exp_rd.push_back(32'h0001_0004);
    exp_rd.push_back(32'h0002_0040);
    push_ack(32'h0101_0003);
    do_lookup("evicted_first", 32'h0041_0000, 3);

    // Flush while the PTE read is outstanding
    hold_addr = 32'h0002_0054;
    hold_en   = 1'b1;
    exp_rd.push_back(32'h0001_0004);
    pw_if.v_addr_i = 32'h0041_5000;
    pw_if.v_lookup = 1'b1;
    cyc = 0;
    while (!(pw_if.rd_o && pw_if.addr_o == hold_addr) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL pte_wait_timeout: addr_o %h, expected %h", pw_if.addr_o, hold_addr);
    end
    pw_if.mmu_base_i = 32'h0001_0123;
    pw_if.mmu_we     = 1'b1;
    @(negedge clk);
    pw_if.mmu_we   = 1'b0;
    pw_if.v_lookup = 1'b0;
    check("abort_rd", 32'(pw_if.rd_o), 32'h0);
    check("abort_base", pw_if.mmu_base_o, 32'h0001_0000);
    repeat (5) @(negedge clk);
    check("late_ack_rd", 32'(pw_if.rd_o), 32'h0);
    hold_en = 1'b0;

    exp_rd.push_back(32'h0001_0004);
    exp_rd.push_back(32'h0002_0048);
    push_ack(32'h0101_2003);
    do_lookup("after_flush", 32'h0041_2000, 3);

    // Slow bus: five wait cycles on each read
    delay = 5;
    exp_rd.push_back(32'h0001_0004);
    exp_rd.push_back(32'h0002_0058);
    push_ack(32'h0101_6003);
    do_lookup("slow_bus", 32'h0041_6ABC, 13);
    delay = 0;

    repeat (3) @(negedge clk);
    check("resp_drained", exp_q.size(), 0);
    check("reads_drained", exp_rd.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
